// File: rtl/pc_bus_pkg.sv
// Shared definitions for the bus read sequencer.
// Holds the FSM state type, the default data/address widths and the default
// RAM read latency used by bus_read_sequencer and its sub-blocks.
package pc_bus_pkg;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultAddrWidth  = 8;
  localparam int unsigned DefaultRamLatency = 2;

  // Holds RAM_LATENCY up to its maximum of 4.
  localparam int unsigned LatCntWidth = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    FINISH
  } state_e;

endpackage

// File: rtl/addr_counter.sv
// Read address register for the burst sequencer.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous reset, active-high (clears address to 0)
//   load_i     load load_val_i (has priority over inc_i)
//   inc_i      increment address, wrapping modulo 2^AddrWidth
//   load_val_i value loaded on load_i
//   addr_o     current address
module addr_counter #(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 inc_i,
  input  logic [AddrWidth-1:0] load_val_i,
  output logic [AddrWidth-1:0] addr_o
);

  logic [AddrWidth-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      // Natural wrap: all-ones + 1 rolls over to zero with no flag.
      addr_d = addr_q + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/bus_read_sequencer.sv
// Burst read sequencer: reads Length consecutive words from a fixed-latency
// RAM starting at BaseAddr and presents each one on a shared bus with a
// valid/ready handshake. Exactly one RAM read is in flight at a time.
// Ports:
//   Clk, Rst   clock and synchronous active-high reset
//   Start      one-cycle burst request (ignored while Busy)
//   BaseAddr   first address, sampled with Start
//   Length     word count, sampled with Start (0 = empty burst)
//   ram_en     RAM read strobe, ram_addr read address, ram_dout read data
//   BusIn      word presented to the bus, BusValid marks it held
//   BusReady   consumer takes BusIn this cycle
//   Busy       burst in progress, Done one-cycle pulse at burst end
module bus_read_sequencer
  import pc_bus_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned RAM_LATENCY = DefaultRamLatency
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [ADDR_WIDTH-1:0] Length,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [WIDTH-1:0]      BusIn,
  output logic                  BusValid,
  input  logic                  BusReady,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [LatCntWidth-1:0] LatLoad = LatCntWidth'(RAM_LATENCY);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
  logic [LatCntWidth-1:0]  lat_cnt_q, lat_cnt_d;
  logic [LatCntWidth-1:0]  lat_cnt_dec;
  logic [WIDTH-1:0]        bus_in_q, bus_in_d;
  logic                    bus_valid_q, bus_valid_d;
  logic                    addr_load, addr_inc;
  logic [ADDR_WIDTH-1:0]   addr;

  addr_counter #(
    .AddrWidth (ADDR_WIDTH)
  ) u_addr_counter (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (addr_load),
    .inc_i      (addr_inc),
    .load_val_i (BaseAddr),
    .addr_o     (addr)
  );

  assign lat_cnt_dec = lat_cnt_q - LatCntWidth'(1);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lat_cnt_d   = lat_cnt_q;
    bus_in_d    = bus_in_q;
    bus_valid_d = bus_valid_q;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Length != '0) begin
            addr_load   = 1'b1;
            remaining_d = Length;
            state_d     = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ISSUE: begin
        lat_cnt_d = LatLoad;
        state_d   = WAIT;
      end
      WAIT: begin
        // Counter reaching zero marks the cycle ram_dout is valid.
        lat_cnt_d = lat_cnt_dec;
        if (lat_cnt_dec == '0) begin
          bus_in_d    = ram_dout;
          bus_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (bus_valid_q && BusReady) begin
          bus_valid_d = 1'b0;
          remaining_d = remaining_q - ADDR_WIDTH'(1);
          if (remaining_q == ADDR_WIDTH'(1)) begin
            state_d = FINISH;
          end else begin
            addr_inc = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      bus_in_q    <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lat_cnt_q   <= lat_cnt_d;
      bus_in_q    <= bus_in_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign ram_en   = (state_q == ISSUE);
  assign ram_addr = addr;
  assign BusIn    = bus_in_q;
  assign BusValid = bus_valid_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == FINISH);

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Directed bench for bus_read_sequencer. Three instances share stimulus:
// a (RAM_LATENCY=2) is checked in detail, b (1) and c (4) for latency.
// Each RAM model returns addr^0xA5 exactly RAM_LATENCY cycles after ram_en
// and 0xEE at any other time, so mistimed captures show up as wrong data.
module tb_bus_read_sequencer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] BaseAddr = 8'h00;
  logic [7:0] Length = 8'h00;
  logic       BusReady = 1'b0;

  logic       ram_en_a, ram_en_b, ram_en_c;
  logic [7:0] ram_addr_a, ram_addr_b, ram_addr_c;
  logic [7:0] ram_dout_a, ram_dout_b, ram_dout_c;
  logic [7:0] bus_in_a, bus_in_b, bus_in_c;
  logic       bus_valid_a, bus_valid_b, bus_valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  bus_read_sequencer #(.WIDTH(8), .ADDR_WIDTH(8), .RAM_LATENCY(2)) dut_a (
    .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
    .ram_en(ram_en_a), .ram_addr(ram_addr_a), .ram_dout(ram_dout_a),
    .BusIn(bus_in_a), .BusValid(bus_valid_a), .BusReady(BusReady),
    .Busy(busy_a), .Done(done_a)
  );
  bus_read_sequencer #(.WIDTH(8), .ADDR_WIDTH(8), .RAM_LATENCY(1)) dut_b (
    .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
    .ram_en(ram_en_b), .ram_addr(ram_addr_b), .ram_dout(ram_dout_b),
    .BusIn(bus_in_b), .BusValid(bus_valid_b), .BusReady(BusReady),
    .Busy(busy_b), .Done(done_b)
  );
  bus_read_sequencer #(.WIDTH(8), .ADDR_WIDTH(8), .RAM_LATENCY(4)) dut_c (
    .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
    .ram_en(ram_en_c), .ram_addr(ram_addr_c), .ram_dout(ram_dout_c),
    .BusIn(bus_in_c), .BusValid(bus_valid_c), .BusReady(BusReady),
    .Busy(busy_c), .Done(done_c)
  );

  // RAM models: pipelines of (data, valid), tapped at the configured latency.
  logic [7:0] pa_d [2] = '{default: 8'h00};
  logic [1:0] pa_v = 2'b00;
  logic [7:0] pb_d = 8'h00;
  logic       pb_v = 1'b0;
  logic [7:0] pc_d [4] = '{default: 8'h00};
  logic [3:0] pc_v = 4'b0000;

  always @(posedge Clk) begin
    pa_d[0] <= ram_addr_a ^ 8'hA5;
    pa_d[1] <= pa_d[0];
    pa_v    <= {pa_v[0], ram_en_a};
    pb_d    <= ram_addr_b ^ 8'hA5;
    pb_v    <= ram_en_b;
    pc_d[0] <= ram_addr_c ^ 8'hA5;
    for (int k = 1; k < 4; k++) pc_d[k] <= pc_d[k-1];
    pc_v    <= {pc_v[2:0], ram_en_c};
  end

  assign ram_dout_a = pa_v[1] ? pa_d[1] : 8'hEE;
  assign ram_dout_b = pb_v    ? pb_d    : 8'hEE;
  assign ram_dout_c = pc_v[3] ? pc_d[3] : 8'hEE;

  // Event log, sampled mid-cycle; cyc is the index of the current cycle.
  int         en_cyc_a[$];
  logic [7:0] en_addr_a[$];
  int         acc_cyc_a[$];
  logic [7:0] acc_data_a[$];
  int         done_cyc_a[$];
  int         valid_cnt_a = 0;
  int         en_cyc_b[$];
  int         val_cyc_b[$];
  int         en_cyc_c[$];
  int         val_cyc_c[$];

  always @(negedge Clk) begin
    if (ram_en_a) begin
      en_cyc_a.push_back(cyc);
      en_addr_a.push_back(ram_addr_a);
    end
    if (bus_valid_a && BusReady) begin
      acc_cyc_a.push_back(cyc);
      acc_data_a.push_back(bus_in_a);
    end
    if (bus_valid_a) valid_cnt_a = valid_cnt_a + 1;
    if (done_a) done_cyc_a.push_back(cyc);
    if (ram_en_b) en_cyc_b.push_back(cyc);
    if (bus_valid_b) val_cyc_b.push_back(cyc);
    if (ram_en_c) en_cyc_c.push_back(cyc);
    if (bus_valid_c) val_cyc_c.push_back(cyc);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mon();
    en_cyc_a.delete();
    en_addr_a.delete();
    acc_cyc_a.delete();
    acc_data_a.delete();
    done_cyc_a.delete();
    valid_cnt_a = 0;
    en_cyc_b.delete();
    val_cyc_b.delete();
    en_cyc_c.delete();
    val_cyc_c.delete();
  endtask

  // Reset with Start and BusReady also high: reset must win.
  task automatic test_reset();
    Rst = 1'b1; Start = 1'b1; BusReady = 1'b1; BaseAddr = 8'h33; Length = 8'd5;
    idle(2);
    checks++;
    if ({ram_en_a, bus_valid_a, busy_a, done_a} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", {ram_en_a, bus_valid_a, busy_a, done_a}, 4'b0);
    end
    checks++;
    if (bus_in_a !== 8'h00 || ram_addr_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=00/00", bus_in_a, ram_addr_a);
    end
    Rst = 1'b0; Start = 1'b0; BusReady = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || busy_c !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority busy got=%b%b exp=00", busy_a, busy_c);
    end
  endtask

  task automatic test_burst_ready();
    int s;
    int exp_e [3];
    logic [7:0] exp_ad [3];
    logic [7:0] exp_w [3];
    exp_e  = '{1, 5, 9};
    exp_ad = '{8'h10, 8'h11, 8'h12};
    exp_w  = '{8'hB5, 8'hB4, 8'hB7};
    clear_mon();
    BaseAddr = 8'h10; Length = 8'd3; BusReady = 1'b1; Start = 1'b1; s = cyc;
    for (int i = 1; i <= 25; i++) begin
      tick();
      Start = 1'b0;
      if (i == 13) begin
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b1) begin
          failures++;
          $display("FAIL burst_done_cycle done=%b busy=%b exp=1/1", done_a, busy_a);
        end
      end
      if (i == 14) begin
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
          failures++;
          $display("FAIL burst_busy_fall busy=%b done=%b exp=0/0", busy_a, done_a);
        end
      end
    end
    checks++;
    if (en_cyc_a.size() != 3 || acc_cyc_a.size() != 3 || done_cyc_a.size() != 1) begin
      failures++;
      $display("FAIL burst_counts en=%0d acc=%0d done=%0d exp=3/3/1",
               en_cyc_a.size(), acc_cyc_a.size(), done_cyc_a.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (en_cyc_a[k] - s != exp_e[k] || en_addr_a[k] !== exp_ad[k] ||
          acc_cyc_a[k] - s != exp_e[k] + 3 || acc_data_a[k] !== exp_w[k]) begin
        failures++;
        $display("FAIL burst_beat%0d en@%0d addr=%h acc@%0d data=%h exp en@%0d addr=%h acc@%0d data=%h",
                 k, en_cyc_a[k] - s, en_addr_a[k], acc_cyc_a[k] - s, acc_data_a[k],
                 exp_e[k], exp_ad[k], exp_e[k] + 3, exp_w[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s;
    clear_mon();
    BaseAddr = 8'h40; Length = 8'd1; BusReady = 1'b0; Start = 1'b1; s = cyc;
    tick();
    Start = 1'b0;
    idle(3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_valid_a !== 1'b1 || bus_in_a !== 8'hE5) begin
        failures++;
        $display("FAIL backpressure_hold%0d valid=%b data=%h exp=1/e5", i, bus_valid_a, bus_in_a);
      end
      tick();
    end
    BusReady = 1'b1;
    tick();
    BusReady = 1'b0;
    checks++;
    if (done_a !== 1'b1 || bus_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_accept done=%b valid=%b exp=1/0", done_a, bus_valid_a);
    end
    idle(15);
    checks++;
    if (en_cyc_a.size() != 1 || acc_cyc_a.size() != 1 || acc_cyc_a[0] - s != 9 ||
        acc_data_a[0] !== 8'hE5) begin
      failures++;
      $display("FAIL backpressure_log en=%0d acc=%0d acc@%0d data=%h exp=1/1/9/e5",
               en_cyc_a.size(), acc_cyc_a.size(), acc_cyc_a[0] - s, acc_data_a[0]);
    end
  endtask

  task automatic test_empty_ignored();
    int s;
    clear_mon();
    BaseAddr = 8'h55; Length = 8'd0; Start = 1'b1; BusReady = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL empty_done done=%b busy=%b exp=1/1", done_a, busy_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL empty_idle done=%b busy=%b exp=0/0", done_a, busy_a);
    end
    idle(3);
    checks++;
    if (en_cyc_a.size() != 0 || done_cyc_a.size() != 1) begin
      failures++;
      $display("FAIL empty_log en=%0d done=%0d exp=0/1", en_cyc_a.size(), done_cyc_a.size());
    end
    // Second Start lands in WAIT and must not touch addr or remaining.
    clear_mon();
    BaseAddr = 8'h20; Length = 8'd2; Start = 1'b1; s = cyc;
    tick();
    Start = 1'b0;
    tick();
    BaseAddr = 8'h80; Length = 8'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    idle(25);
    checks++;
    if (en_cyc_a.size() != 2 || acc_cyc_a.size() != 2 || done_cyc_a.size() != 1 ||
        done_cyc_a[0] - s != 9) begin
      failures++;
      $display("FAIL ignored_counts en=%0d acc=%0d done=%0d done@%0d exp=2/2/1/9",
               en_cyc_a.size(), acc_cyc_a.size(), done_cyc_a.size(), done_cyc_a[0] - s);
    end
    checks++;
    if (en_addr_a[0] !== 8'h20 || en_addr_a[1] !== 8'h21 ||
        acc_data_a[0] !== 8'h85 || acc_data_a[1] !== 8'h84) begin
      failures++;
      $display("FAIL ignored_data addr=%h,%h data=%h,%h exp=20,21 85,84",
               en_addr_a[0], en_addr_a[1], acc_data_a[0], acc_data_a[1]);
    end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] exp_ad [3];
    logic [7:0] exp_w [3];
    exp_ad = '{8'hFE, 8'hFF, 8'h00};
    exp_w  = '{8'h5B, 8'h5A, 8'hA5};
    clear_mon();
    BaseAddr = 8'hFE; Length = 8'd3; BusReady = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    idle(25);
    checks++;
    if (en_addr_a.size() != 3 || acc_data_a.size() != 3) begin
      failures++;
      $display("FAIL wrap_counts en=%0d acc=%0d exp=3/3", en_addr_a.size(), acc_data_a.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (en_addr_a[k] !== exp_ad[k] || acc_data_a[k] !== exp_w[k]) begin
        failures++;
        $display("FAIL wrap_beat%0d addr=%h data=%h exp=%h/%h",
                 k, en_addr_a[k], acc_data_a[k], exp_ad[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    BaseAddr = 8'h30; Length = 8'd2; BusReady = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b1 || ram_en_a !== 1'b0 || bus_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL resetmid_wait busy=%b en=%b valid=%b exp=1/0/0", busy_a, ram_en_a, bus_valid_a);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if ({ram_en_a, bus_valid_a, busy_a, done_a} !== 4'b0000 ||
        bus_in_a !== 8'h00 || ram_addr_a !== 8'h00) begin
      failures++;
      $display("FAIL resetmid_outputs flags=%b busin=%h addr=%h exp=0000/00/00",
               {ram_en_a, bus_valid_a, busy_a, done_a}, bus_in_a, ram_addr_a);
    end
    idle(12);
    checks++;
    if (done_cyc_a.size() != 0 || valid_cnt_a != 0 || en_cyc_a.size() != 1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL resetmid_after done=%0d valid=%0d en=%0d busy=%b exp=0/0/1/0",
               done_cyc_a.size(), valid_cnt_a, en_cyc_a.size(), busy_a);
    end
  endtask

  task automatic test_param_sweep();
    clear_mon();
    BaseAddr = 8'h05; Length = 8'd1; BusReady = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    idle(15);
    checks++;
    if (en_cyc_b.size() != 1 || val_cyc_b.size() != 1 || val_cyc_b[0] - en_cyc_b[0] != 2) begin
      failures++;
      $display("FAIL sweep_lat1 en=%0d valid=%0d lat=%0d exp=1/1/2",
               en_cyc_b.size(), val_cyc_b.size(), val_cyc_b[0] - en_cyc_b[0]);
    end
    checks++;
    if (en_cyc_c.size() != 1 || val_cyc_c.size() != 1 || val_cyc_c[0] - en_cyc_c[0] != 5) begin
      failures++;
      $display("FAIL sweep_lat4 en=%0d valid=%0d lat=%0d exp=1/1/5",
               en_cyc_c.size(), val_cyc_c.size(), val_cyc_c[0] - en_cyc_c[0]);
    end
    checks++;
    if (bus_in_b !== 8'hA0 || bus_in_c !== 8'hA0 || acc_data_a[0] !== 8'hA0) begin
      failures++;
      $display("FAIL sweep_data b=%h c=%h a=%h exp=a0", bus_in_b, bus_in_c, acc_data_a[0]);
    end
  endtask

  initial begin
    test_reset();
    test_burst_ready();
    idle(5);
    test_backpressure();
    test_empty_ignored();
    idle(5);
    test_addr_wrap();
    test_reset_mid();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_read_sequencer.md
BUS_READ_SEQUENCER -- requirements
Module: bus_read_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, data word width on RAM and bus.
REQ-002 Parameter: ADDR_WIDTH, default 8, RAM address width.
REQ-003 Parameter: RAM_LATENCY, default 2, cycles from ram_en edge to valid ram_dout (range 1..4).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports named as follows:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous reset, active-high.
REQ-005 The block SHALL have the following ports:
- Start  input  1  one-cycle request to begin a burst.
- BaseAddr  input  ADDR_WIDTH  first address, sampled with Start.
- Length  input  ADDR_WIDTH  word count, sampled with Start; 0 = empty burst.
- ram_en  output  1  RAM read strobe.
- ram_addr  output  ADDR_WIDTH  RAM read address.
- ram_dout  input  WIDTH  RAM read data.
- BusIn  output  WIDTH  word presented to the shared bus.
- BusValid  output  1  BusIn holds a word.
- BusReady  input  1  consumer register captures BusIn this cycle (drives its WEN).
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse at burst end.

Function
REQ-006 FSM states SHALL be: IDLE, ISSUE, WAIT, PRESENT, FINISH.
REQ-007 IDLE: on Start with Length!=0, the block SHALL latch addr=BaseAddr and remaining=Length, then go to ISSUE.
REQ-008 IDLE: on Start with Length==0, the block SHALL go to FINISH with no ram_en pulse.
REQ-009 ISSUE: ram_en=1 and ram_addr=addr for exactly one cycle, with a latency counter loaded to RAM_LATENCY; then go to WAIT.
REQ-010 WAIT: the counter SHALL decrement each cycle; at 0, ram_dout is captured into the BusIn register, BusValid is set next cycle, and the state goes to PRESENT.
REQ-011 Latency SHALL be exactly RAM_LATENCY+1 cycles from the ram_en cycle to the first BusValid cycle.
REQ-012 PRESENT: BusIn and BusValid SHALL hold stable until a cycle with BusValid&&BusReady (an acceptance).
REQ-013 On acceptance, BusValid SHALL clear next cycle and remaining SHALL decrement.
REQ-014 After acceptance, if remaining was 1, go to FINISH; otherwise addr increments and the state goes to ISSUE.
REQ-015 The address SHALL increment modulo 2^ADDR_WIDTH (0xFF+1 -> 0x00 at default width), with no error flagged.
REQ-016 FINISH: Done=1 for one cycle, then go to IDLE.
REQ-017 Busy SHALL be 1 in every state except IDLE.
REQ-018 Start while Busy SHALL be ignored and SHALL NOT alter addr or remaining.
REQ-019 Only one RAM read SHALL be in flight; ram_en is never asserted outside ISSUE.
REQ-020 BusReady while BusValid=0 SHALL have no effect.
REQ-021 Acceptance throughput SHALL be at most one word per RAM_LATENCY+2 cycles.

Reset
REQ-022 While Rst=1 at a Clk edge, the state SHALL go to IDLE with ram_en=0, BusValid=0, Busy=0, Done=0, BusIn=0, ram_addr=0, and internal counters=0.
REQ-023 Reset mid-burst SHALL abort without a Done pulse; any RAM data returning afterwards SHALL be ignored.
REQ-024 Rst SHALL take priority over Start and BusReady in the same cycle.

Structure
REQ-025 Shared package pc_bus_pkg SHALL hold the state enum, the default WIDTH/ADDR_WIDTH values, and the RAM_LATENCY default.
REQ-026 Sub-module addr_counter (load, increment, synchronous reset) SHALL hold addr; the FSM, remaining count and latency counter stay in the top level.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Burst, ready held high: Start, BaseAddr=0x10, Length=3, RAM returns addr^0xA5, BusReady=1 -> BusIn 0xB5, 0xB4, 0xB7; first BusValid 3 cycles after ram_en; Done pulse once; Busy falls after Done.
- Backpressure: Length=1, BusReady low 5 cycles after BusValid -> BusIn stable all 5 cycles; one ram_en total; accepted on first BusReady=1.
- Empty and ignored requests: Length=0 -> Done next cycle, ram_en never high; a Start during a burst -> ignored, remaining unchanged.
- Address wrap: BaseAddr=0xFE, Length=3 -> ram_addr 0xFE, 0xFF, 0x00.
- Reset mid-burst: Rst asserted during WAIT -> all outputs 0 next cycle, no Done, no BusValid.
- Parameter sweep: RAM_LATENCY=1 and 4 -> ram_en-to-BusValid latency of 2 and 5 cycles respectively.
